// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock-enable divider.
package clk_div_pkg;

    // Output behaviour of a channel
    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam int unsigned NUM_CH_DFLT  = 4;
    localparam int unsigned CNT_W_DFLT   = 32;
    localparam int unsigned DEF_DIV_DFLT = 0;

    // Width of a channel index; never narrower than one bit
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, shadow/active configuration and registered outputs.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DFLT,
    parameter int unsigned DEF_DIV = DEF_DIV_DFLT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  mode_e            wr_mode,
    output logic             pending,
    output logic             div,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] shd_div;
    mode_e            act_mode;
    mode_e            shd_mode;
    logic             tc_c;
    logic             apply_c;
    logic             mode_chg_c;

    // Terminal count, and the only moments a shadow config may become active
    always_comb begin
        tc_c       = en & ~sync & (cnt == act_div);
        apply_c    = pending & (tc_c | sync | ~en);
        mode_chg_c = apply_c & (shd_mode != act_mode);
    end

    // Configuration hand-off, period counter and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt      <= '0;
            act_div  <= CNT_W'(DEF_DIV);
            shd_div  <= CNT_W'(DEF_DIV);
            act_mode <= MODE_TOGGLE;
            shd_mode <= MODE_TOGGLE;
            pending  <= 1'b0;
            div      <= 1'b0;
            tick     <= 1'b0;
        end else begin
            // A write is only accepted while nothing is pending, so it never meets an apply
            if (apply_c) begin
                act_div  <= shd_div;
                act_mode <= shd_mode;
                pending  <= 1'b0;
            end else if (wr) begin
                shd_div  <= wr_div;
                shd_mode <= wr_mode;
                pending  <= 1'b1;
            end

            if (sync || !en) begin
                cnt  <= '0;
                tick <= 1'b0;
                div  <= 1'b0;
            end else if (tc_c) begin
                cnt  <= '0;
                tick <= 1'b1;
                div  <= (act_mode == MODE_TOGGLE) ? ~div : 1'b1;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
                div  <= (act_mode == MODE_TOGGLE) ? div : 1'b0;
            end

            // Start a new mode from a known low level
            if (mode_chg_c) begin
                div <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Bank of independent clock-enable dividers sharing one configuration port.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int unsigned NUM_CH  = NUM_CH_DFLT,
    parameter  int unsigned CNT_W   = CNT_W_DFLT,
    parameter  int unsigned DEF_DIV = DEF_DIV_DFLT,
    localparam int unsigned CH_W    = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_i,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] div_o,
    output logic [NUM_CH-1:0] tick_o
);

    // Every encodable channel index gets a slot; unused slots never block
    localparam int unsigned NUM_SLOT = 1 << CH_W;

    logic [NUM_CH-1:0]   pending;
    logic [NUM_SLOT-1:0] pend_pad;

    // Ready follows the registered pending flag of the addressed channel
    always_comb begin
        pend_pad  = NUM_SLOT'(pending);
        cfg_ready = ~pend_pad[cfg_ch];
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_c;

        // Transfer strobe for this channel only
        always_comb begin
            wr_c = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
        end

        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk     (clk),
            .rstn    (rstn),
            .en      (ch_en[i]),
            .sync    (sync_i),
            .wr      (wr_c),
            .wr_div  (cfg_div),
            .wr_mode (mode_e'(cfg_mode)),
            .pending (pending[i]),
            .div     (div_o[i]),
            .tick    (tick_o[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi against a countdown-based reference model.
module tb_clk_div_multi;

    localparam int unsigned NCH  = 5;
    localparam int unsigned CW   = 32;
    localparam int unsigned DEFD = 3;
    localparam int unsigned CHW  = 3;

    logic            clk;
    logic            rstn;
    logic [NCH-1:0]  ch_en;
    logic            sync_i;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CHW-1:0]  cfg_ch;
    logic [CW-1:0]   cfg_div;
    logic            cfg_mode;
    logic [NCH-1:0]  div_o;
    logic [NCH-1:0]  tick_o;

    clk_div_multi #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .DEF_DIV (DEFD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ch_en     (ch_en),
        .sync_i    (sync_i),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .div_o     (div_o),
        .tick_o    (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: edges remaining until the next tick, plus config state
    logic [CW-1:0]    m_adiv [NCH];
    logic [CW-1:0]    m_sdiv [NCH];
    bit               m_amode[NCH];
    bit               m_smode[NCH];
    bit               m_pend [NCH];
    bit               m_lvl  [NCH];
    bit               m_tick [NCH];
    longint unsigned  m_rem  [NCH];

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < int'(NCH); i++) begin
            bit en, wr, tc, apply, old_mode;
            if (!rstn) begin
                m_adiv[i]  = DEFD;
                m_sdiv[i]  = DEFD;
                m_amode[i] = 1'b0;
                m_smode[i] = 1'b0;
                m_pend[i]  = 1'b0;
                m_lvl[i]   = 1'b0;
                m_tick[i]  = 1'b0;
                m_rem[i]   = 64'(DEFD) + 64'd1;
                continue;
            end
            en       = ch_en[i];
            wr       = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
            tc       = en && !sync_i && (m_rem[i] == 64'd1);
            apply    = m_pend[i] && (tc || sync_i || !en);
            old_mode = m_amode[i];
            if (apply) begin
                m_adiv[i]  = m_sdiv[i];
                m_amode[i] = m_smode[i];
                m_pend[i]  = 1'b0;
            end else if (wr) begin
                m_sdiv[i]  = cfg_div;
                m_smode[i] = cfg_mode;
                m_pend[i]  = 1'b1;
            end
            if (sync_i || !en) begin
                m_rem[i]  = 64'(m_adiv[i]) + 64'd1;
                m_tick[i] = 1'b0;
                m_lvl[i]  = 1'b0;
            end else if (tc) begin
                m_rem[i]  = 64'(m_adiv[i]) + 64'd1;
                m_tick[i] = 1'b1;
                m_lvl[i]  = old_mode ? 1'b1 : ~m_lvl[i];
            end else begin
                m_rem[i]  = m_rem[i] - 64'd1;
                m_tick[i] = 1'b0;
                m_lvl[i]  = old_mode ? 1'b0 : m_lvl[i];
            end
            if (apply && (m_amode[i] != old_mode)) m_lvl[i] = 1'b0;
        end
    endtask

    // One clock: check ready before the edge, step the model, check outputs after it
    task automatic cycle();
        logic [NCH-1:0] exp_div, exp_tick;
        bit             exp_rdy;
        #1;
        if (int'(cfg_ch) >= int'(NCH)) exp_rdy = 1'b1;
        else                           exp_rdy = !m_pend[int'(cfg_ch)];
        check("cfg_ready", 64'(cfg_ready), 64'(exp_rdy));
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < int'(NCH); i++) begin
            exp_div[i]  = m_lvl[i];
            exp_tick[i] = m_tick[i];
        end
        check("div_o", 64'(div_o), 64'(exp_div));
        check("tick_o", 64'(tick_o), 64'(exp_tick));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic cfg(input int ch, input logic [CW-1:0] d, input bit m);
        cfg_valid = 1'b1;
        cfg_ch    = CHW'(ch);
        cfg_div   = d;
        cfg_mode  = m;
        cycle();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int cnt_a, cnt_b, first_a, first_b;
        n_vec     = 0;
        n_err     = 0;
        rstn      = 1'b0;
        ch_en     = '0;
        sync_i    = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_mode  = 1'b0;
        @(negedge clk);
        idle(2);
        rstn = 1'b1;

        // ch0 D=0 toggle: tick every cycle
        cfg(0, 32'd0, 1'b0);
        idle(1);
        ch_en[0] = 1'b1;
        cnt_a = 0;
        for (int k = 0; k < 6; k++) begin cycle(); cnt_a += int'(tick_o[0]); end
        check("ch0_d0_ticks", 64'(cnt_a), 64'd6);

        // ch1 D=4 toggle: ticks at edges 5,10,15,20; div high 10 of 20
        cfg(1, 32'd4, 1'b0);
        idle(1);
        ch_en[1] = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            cnt_a += int'(tick_o[1]);
            cnt_b += int'(div_o[1]);
        end
        check("ch1_ticks", 64'(cnt_a), 64'd4);
        check("ch1_div_high", 64'(cnt_b), 64'd10);

        // ch2 D=3 reconfigured mid-period to D=7
        cfg(2, 32'd3, 1'b0);
        idle(1);
        ch_en[2] = 1'b1;
        idle(2);
        cfg(2, 32'd7, 1'b0);
        idle(14);

        // ch0 D=2, ch1 D=5, sync on a ch0 terminal-count cycle
        ch_en = '0;
        cfg(0, 32'd2, 1'b0);
        cfg(1, 32'd5, 1'b0);
        idle(1);
        ch_en = NCH'(3);
        idle(int'($urandom_range(0, 4)));
        for (int k = 0; k < 4 && m_rem[0] != 64'd1; k++) cycle();
        sync_i = 1'b1;
        cycle();
        sync_i = 1'b0;
        check("sync_no_tick", 64'(tick_o[0]), 64'd0);
        first_a = 0;
        first_b = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (tick_o[0] && first_a == 0) first_a = k;
            if (tick_o[1] && first_b == 0) first_b = k;
        end
        check("ch0_after_sync", 64'(first_a), 64'd3);
        check("ch1_after_sync", 64'(first_b), 64'd6);

        // Pending cfg on ch3 discarded by reset; ch3 back to DEF_DIV
        ch_en[3] = 1'b1;
        idle(2);
        cfg(3, 32'd9, 1'b0);
        rstn = 1'b0;
        cycle();
        rstn  = 1'b1;
        cfg_ch = 3'd3;
        first_a = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (tick_o[3] && first_a == 0) first_a = k;
        end
        check("ch3_def_first_tick", 64'(first_a), 64'(DEFD + 1));

        // ch0 pulse mode D=1: div follows tick, high every other cycle
        ch_en = NCH'(1);
        cfg(0, 32'd1, 1'b1);
        idle(4);
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            cnt_a += int'(div_o[0] != tick_o[0]);
            cnt_b += int'(div_o[0]);
        end
        check("ch0_pulse_eq", 64'(cnt_a), 64'd0);
        check("ch0_pulse_high", 64'(cnt_b), 64'd5);

        // Out-of-range channel accepted and dropped
        cfg(int'(NCH), 32'd2, 1'b1);
        idle(4);

        // Largest divisor: no tick within a short window
        ch_en[4] = 1'b1;
        cfg(4, 32'hFFFF_FFFF, 1'b0);
        idle(8);
        cnt_a = 0;
        for (int k = 0; k < 20; k++) begin cycle(); cnt_a += int'(tick_o[4]); end
        check("ch4_max_no_tick", 64'(cnt_a), 64'd0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rstn   = ($urandom_range(0, 199) != 0);
            sync_i = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < int'(NCH); i++)
                if ($urandom_range(0, 39) == 0) ch_en[i] = ~ch_en[i];
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CHW'($urandom_range(0, 7));
            cfg_div   = CW'($urandom_range(0, 9));
            cfg_mode  = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: divisor and counter width.
REQ-003 SHALL have parameter DEF_DIV, default 0: divisor loaded on reset in every channel.
REQ-004 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn  in  1: reset, synchronous, active-low.
REQ-006 SHALL have port ch_en  in  NUM_CH: per-channel run enable.
REQ-007 SHALL have port sync_i  in  1: one-cycle pulse that re-phases all channels.
REQ-008 SHALL have port cfg_valid  in  1: configuration request.
REQ-009 SHALL have port cfg_ready  out  1: configuration accept.
REQ-010 SHALL have port cfg_ch  in  max(1,clog2(NUM_CH)): target channel.
REQ-011 SHALL have port cfg_div  in  CNT_W: divisor D.
REQ-012 SHALL have port cfg_mode  in  1: 0 = toggle (50% clock), 1 = pulse.
REQ-013 SHALL have port div_o  out  NUM_CH: divided output level, registered.
REQ-014 SHALL have port tick_o  out  NUM_CH: one-cycle terminal-count strobe, registered.

Function
REQ-015 SHALL keep per channel: counter cnt, active divisor/mode, shadow divisor/mode, pending flag.
REQ-016 SHALL, while ch_en[i]=1 and no sync, increment cnt[i] each cycle; at cnt[i]==D (unsigned compare, full CNT_W) set cnt[i]<=0 and tick_o[i]<=1 for one cycle.
REQ-017 SHALL give a terminal-count period of exactly D+1 cycles; D=0 gives tick_o high every cycle; D=2^CNT_W-1 is legal, counter never overflows.
REQ-018 SHALL, in toggle mode, invert div_o[i] at each terminal count (period 2(D+1), 50% duty).
REQ-019 SHALL, in pulse mode, drive div_o[i] identical to tick_o[i].
REQ-020 SHALL, while ch_en[i]=0, hold cnt[i]=0, div_o[i]=0, tick_o[i]=0.
REQ-021 SHALL make the first tick after ch_en[i] rises occur after the (D+1)-th rising edge sampling ch_en[i]=1.
REQ-022 SHALL drive cfg_ready = ~pending[cfg_ch] combinationally; transfer occurs when cfg_valid & cfg_ready at a rising edge.
REQ-023 SHALL, on transfer, write cfg_div/cfg_mode into the channel shadow and set pending.
REQ-024 SHALL copy shadow to active and clear pending at the channel's next terminal count, sync_i, or immediately (next edge) if ch_en[i]=0; never mid-period.
REQ-025 SHALL, when a mode change is applied, force div_o[i] to 0 on that edge.
REQ-026 SHALL, on sync_i=1, set all cnt to 0 and all div_o/tick_o to 0 at that edge; sync wins over a coincident terminal count (no tick emitted).
REQ-027 SHALL treat out-of-range cfg_ch (>= NUM_CH) as accepted and discarded, cfg_ready=1.
REQ-028 SHALL allow a transfer in the same cycle that pending is being cleared only from the following cycle (cfg_ready reflects registered pending).

Reset
REQ-029 SHALL, on rstn=0 at a rising edge, set cnt=0, active/shadow divisor=DEF_DIV, mode=toggle, pending=0, div_o=0, tick_o=0, regardless of ch_en, sync_i, cfg_valid.
REQ-030 SHALL discard any pending configuration on reset mid-operation; cfg_ready is 1 in the first cycle after reset releases.

Structure
REQ-031 SHALL place mode constants (MODE_TOGGLE=0, MODE_PULSE=1) and DEF_DIV default in shared package clk_div_pkg.
REQ-032 SHALL implement one channel (counter, shadow, pending, output regs) in sub-module clk_div_ch, instantiated NUM_CH times by generate.
REQ-033 SHALL contain no clock gating or generated clocks; div_o is a data signal for enable use only.

Verification
REQ-034 SHALL cover: reset, cfg ch0 D=0 toggle, ch_en[0]=1 -> tick_o[0] high every cycle, div_o[0] toggles every cycle.
REQ-035 SHALL cover: ch1 D=4 toggle, enable -> first tick after 5th edge, then every 5 cycles; div_o[1] period 10, high 5.
REQ-036 SHALL cover: ch2 running D=3, cfg D=7 mid-period -> cfg_ready[ch2] low until next terminal count, current period still 4 cycles, following periods 8.
REQ-037 SHALL cover: ch0 D=2, ch1 D=5 running, sync_i on a ch0 terminal-count cycle -> no tick that cycle, both counters 0, next ticks after 3 and 6 cycles.
REQ-038 SHALL cover: pending cfg on ch3, rstn=0 one cycle -> divisor returns to DEF_DIV, cfg_ready=1, all outputs 0.
REQ-039 SHALL cover: ch0 pulse mode D=1 -> div_o[0]==tick_o[0], high 1 of every 2 cycles; cfg_ch=NUM_CH -> accepted, no channel changes.
